// File: rtl/fpga_hero_pkg.sv
// Shared constants and types for the fpga_hero display path.
// Screen geometry, colour encodings and painter state.
package fpga_hero_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int COLOR_W  = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DRAW = 2'd1,
        ST_DONE = 2'd2
    } painter_state_t;

    localparam logic [COLOR_W-1:0] COLOR_BLACK  = 3'b000;
    localparam logic [COLOR_W-1:0] LANE_RED     = 3'b100;
    localparam logic [COLOR_W-1:0] LANE_GREEN   = 3'b010;
    localparam logic [COLOR_W-1:0] LANE_BLUE    = 3'b001;
    localparam logic [COLOR_W-1:0] LANE_YELLOW  = 3'b110;
    localparam logic [COLOR_W-1:0] PRESS_RED    = 3'b101;
    localparam logic [COLOR_W-1:0] PRESS_GREEN  = 3'b011;
    localparam logic [COLOR_W-1:0] PRESS_BLUE   = 3'b111;
    localparam logic [COLOR_W-1:0] PRESS_YELLOW = 3'b111;

    function automatic logic on_screen(
        input logic [8:0] x,
        input logic [8:0] y,
        input int         sw,
        input int         sh
    );
        return (x < 9'(sw)) && (y < 9'(sh));
    endfunction

endpackage

// File: rtl/pixel_scanner.sv
// Column/row walker over a WIDTH x HEIGHT block.
// Also exposes the following position so the painter can register it.
module pixel_scanner #(
    parameter int WIDTH  = 8,
    parameter int HEIGHT = 8,
    parameter int CW     = (WIDTH  > 1) ? $clog2(WIDTH)  : 1,
    parameter int RW     = (HEIGHT > 1) ? $clog2(HEIGHT) : 1
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          clear,
    input  logic          advance,
    output logic [CW-1:0] col,
    output logic [RW-1:0] row,
    output logic [CW-1:0] col_nxt,
    output logic [RW-1:0] row_nxt,
    output logic          last
);

    logic col_end;

    assign col_end = (col == CW'(WIDTH - 1));
    assign last    = col_end && (row == RW'(HEIGHT - 1));
    assign col_nxt = col_end ? '0 : col + CW'(1);
    assign row_nxt = col_end ? row + RW'(1) : row;

    always_ff @(posedge clock) begin
        if (!resetn || clear) begin
            col <= '0;
            row <= '0;
        end else if (advance) begin
            col <= col_nxt;
            row <= row_nxt;
        end
    end

endmodule

// File: rtl/block_painter.sv
// Rasterises one solid WIDTH x HEIGHT block into the vga_adapter
// pixel-write port, one pixel per clock, clipping off-screen pixels.
module block_painter
    import fpga_hero_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int HEIGHT   = 8,
    parameter int SCREEN_W = fpga_hero_pkg::SCREEN_W,
    parameter int SCREEN_H = fpga_hero_pkg::SCREEN_H
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               go,
    input  logic [7:0]         start_x,
    input  logic [7:0]         start_y,
    input  logic [COLOR_W-1:0] color,
    output logic [7:0]         x_out,
    output logic [7:0]         y_out,
    output logic [COLOR_W-1:0] color_out,
    output logic               plot,
    output logic               done,
    output logic               busy
);

    localparam int CW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    painter_state_t state;

    logic [7:0]    base_x;
    logic [7:0]    base_y;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [CW-1:0] col_nxt;
    logic [RW-1:0] row_nxt;
    logic          last;
    logic          clear;
    logic          advance;
    logic [8:0]    px;
    logic [8:0]    py;

    assign clear   = (state == ST_IDLE);
    assign advance = (state == ST_DRAW) && !last;

    pixel_scanner #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT),
        .CW     (CW),
        .RW     (RW)
    ) u_scanner (
        .clock   (clock),
        .resetn  (resetn),
        .clear   (clear),
        .advance (advance),
        .col     (col),
        .row     (row),
        .col_nxt (col_nxt),
        .row_nxt (row_nxt),
        .last    (last)
    );

    // Outputs are registered, so the address computed here is the pixel
    // that becomes visible after the coming edge: pixel 0 comes straight
    // from the inputs at acceptance, later ones from the latched base.
    always_comb begin
        px = {1'b0, start_x};
        py = {1'b0, start_y};
        if (state != ST_IDLE) begin
            px = {1'b0, base_x} + 9'(col_nxt);
            py = {1'b0, base_y} + 9'(row_nxt);
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state     <= ST_IDLE;
            base_x    <= '0;
            base_y    <= '0;
            x_out     <= '0;
            y_out     <= '0;
            color_out <= '0;
            plot      <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    plot <= 1'b0;
                    done <= 1'b0;
                    busy <= 1'b0;
                    if (go) begin
                        base_x    <= start_x;
                        base_y    <= start_y;
                        color_out <= color;
                        x_out     <= px[7:0];
                        y_out     <= py[7:0];
                        plot      <= on_screen(px, py, SCREEN_W, SCREEN_H);
                        busy      <= 1'b1;
                        state     <= ST_DRAW;
                    end
                end
                ST_DRAW: begin
                    if (last) begin
                        plot  <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        x_out <= px[7:0];
                        y_out <= py[7:0];
                        plot  <= on_screen(px, py, SCREEN_W, SCREEN_H);
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    plot  <= 1'b0;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_block_painter.sv
// Directed self-checking bench for block_painter (default 8x8 block).
// Expected pixels come from a small address/clip model in the bench.
module tb_block_painter;

    logic       clock;
    logic       resetn;
    logic       go;
    logic [7:0] start_x;
    logic [7:0] start_y;
    logic [2:0] color;
    logic [7:0] x_out;
    logic [7:0] y_out;
    logic [2:0] color_out;
    logic       plot;
    logic       done;
    logic       busy;

    int checks;
    int errors;

    block_painter dut (
        .clock     (clock),
        .resetn    (resetn),
        .go        (go),
        .start_x   (start_x),
        .start_y   (start_y),
        .color     (color),
        .x_out     (x_out),
        .y_out     (y_out),
        .color_out (color_out),
        .plot      (plot),
        .done      (done),
        .busy      (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".x"}, 32'(x_out), 0);
        chk({tag, ".y"}, 32'(y_out), 0);
        chk({tag, ".c"}, 32'(color_out), 0);
        chk({tag, ".plot"}, 32'(plot), 0);
        chk({tag, ".done"}, 32'(done), 0);
        chk({tag, ".busy"}, 32'(busy), 0);
    endtask

    // Presents a request and follows it to its done cycle. Midway the
    // inputs are disturbed to show they were latched at acceptance.
    // If abort_at > 0 the task stops after observing that pixel.
    task automatic draw(input string tag, input int sx, input int sy,
                        input logic [2:0] c, input int exp_plots,
                        input int abort_at);
        int plots;
        int xs;
        int ys;
        logic pe;
        plots   = 0;
        go      = 1'b1;
        start_x = 8'(sx);
        start_y = 8'(sy);
        color   = c;
        for (int cyc = 1; cyc <= 65; cyc++) begin
            tick();
            if (cyc <= 64) begin
                xs = sx + (cyc - 1) % 8;
                ys = sy + (cyc - 1) / 8;
                pe = (xs < 160) && (ys < 120);
                chk({tag, ".x"}, 32'(x_out), 32'(xs & 255));
                chk({tag, ".y"}, 32'(y_out), 32'(ys & 255));
                chk({tag, ".plot"}, 32'(plot), 32'(pe));
                chk({tag, ".color"}, 32'(color_out), 32'(c));
                chk({tag, ".done"}, 32'(done), 0);
                chk({tag, ".busy"}, 32'(busy), 1);
                if (plot === 1'b1) plots++;
                if (cyc == 11) begin
                    color   = ~c;
                    start_x = 8'(sx + 3);
                    start_y = 8'(sy + 1);
                end
                if (abort_at > 0 && cyc - 1 == abort_at) return;
            end else begin
                chk({tag, ".done_hi"}, 32'(done), 1);
                chk({tag, ".plot_done"}, 32'(plot), 0);
                chk({tag, ".busy_done"}, 32'(busy), 1);
                chk({tag, ".nplots"}, 32'(plots), 32'(exp_plots));
            end
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        resetn  = 1'b0;
        go      = 1'b0;
        start_x = 8'd0;
        start_y = 8'd0;
        color   = 3'd0;

        tick();
        tick();
        chk_zero("reset");

        resetn = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            chk("idle.plot", 32'(plot), 0);
            chk("idle.done", 32'(done), 0);
            chk("idle.busy", 32'(busy), 0);
        end

        draw("basic", 60, 110, 3'b100, 64, 0);
        go = 1'b0;
        tick();
        chk("basic.post_busy", 32'(busy), 0);
        chk("basic.post_done", 32'(done), 0);
        chk("basic.hold_c", 32'(color_out), 32'(3'b100));
        tick();
        chk("basic.idle_busy", 32'(busy), 0);
        chk("basic.idle_plot", 32'(plot), 0);

        draw("clip", 156, 116, 3'b010, 16, 0);
        go = 1'b0;
        tick();
        chk("clip.post_busy", 32'(busy), 0);

        draw("wrapy", 60, 246, 3'b001, 0, 0);
        go = 1'b0;
        tick();
        chk("wrapy.post_busy", 32'(busy), 0);

        draw("b2b_a", 60, 110, 3'b110, 64, 0);
        start_x = 8'd70;
        start_y = 8'd110;
        color   = 3'b011;
        tick();
        chk("b2b.gap_busy", 32'(busy), 0);
        chk("b2b.gap_done", 32'(done), 0);
        chk("b2b.gap_plot", 32'(plot), 0);
        draw("b2b_b", 70, 110, 3'b011, 64, 0);
        go = 1'b0;
        tick();
        chk("b2b.post_busy", 32'(busy), 0);

        draw("abort", 60, 110, 3'b101, 64, 20);
        resetn = 1'b0;
        tick();
        chk_zero("abort");
        resetn = 1'b1;
        draw("restart", 60, 110, 3'b111, 64, 0);
        go = 1'b0;
        tick();
        chk("restart.post_busy", 32'(busy), 0);
        chk("restart.post_done", 32'(done), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
